// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: MIPS-style coprocessor-0 exception and interrupt controller.
// This block holds the BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config registers.
// It prioritises the exception flags of the committing instruction.
// It redirects the pipeline with zero latency on a taken exception or ERET.
module cp0_exc_ctrl #(
   parameter int          HW_INT_W   = 6,
   parameter int          COUNT_DIV  = 2,
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] PRID       = 32'h004C_0102
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [4:0]          waddr_i,
   input  logic [4:0]          raddr_i,
   input  logic [31:0]         data_i,
   input  logic [HW_INT_W-1:0] int_i,
   input  logic                exc_valid_i,
   input  logic [7:0]          exc_req_i,
   input  logic [31:0]         pc_i,
   input  logic                in_delayslot_i,
   input  logic [31:0]         badvaddr_i,
   output logic [31:0]         data_o,
   output logic [31:0]         status_o,
   output logic [31:0]         cause_o,
   output logic [31:0]         epc_o,
   output logic                flush_o,
   output logic [31:0]         new_pc_o,
   output logic                int_pending_o,
   output logic                timer_int_o
);

   localparam int          PW       = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_DIV - 1);
   localparam logic [31:0] CONFIG_VAL = 32'h0000_8000;

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;
   localparam logic [4:0] A_PRID     = 5'd15;
   localparam logic [4:0] A_CONFIG   = 5'd16;

   logic [31:0]   r_badvaddr;
   logic [31:0]   r_count;
   logic [31:0]   r_compare;
   logic [PW-1:0] r_presc;
   logic [7:0]    r_im;
   logic          r_exl;
   logic          r_ie;
   logic          r_bd;
   logic          r_ti;
   logic [5:0]    r_ip_hw;
   logic [1:0]    r_ip_sw;
   logic [4:0]    r_exccode;
   logic [31:0]   r_epc;

   logic [5:0]    w_int_ext;
   logic [7:0]    w_ip;
   logic [31:0]   w_status;
   logic [31:0]   w_cause;
   logic          w_int_pend;
   logic          w_exc;
   logic          w_eret;
   logic          w_bad_ld;
   logic [4:0]    w_code;
   logic          w_wr_count;
   logic          w_wr_compare;

   // Zero-extend the hardware interrupt lines to the six IP slots.
   always_comb begin
      w_int_ext = '0;
      w_int_ext[HW_INT_W-1:0] = int_i;
   end

   // The timer interrupt shares IP[7] with the top hardware line.
   assign w_ip     = {r_ti | r_ip_hw[5], r_ip_hw[4:0], r_ip_sw};
   assign w_status = {3'b000, 1'b1, 5'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
   assign w_cause  = {r_bd, r_ti, 14'b0, w_ip, 1'b0, r_exccode, 2'b00};

   assign w_int_pend   = r_ie & ~r_exl & (|(w_ip & r_im));
   assign w_wr_count   = we_i && (waddr_i == A_COUNT);
   assign w_wr_compare = we_i && (waddr_i == A_COMPARE);

   // Select the highest-priority event of the committing instruction.
   always_comb begin
      w_exc    = 1'b0;
      w_eret   = 1'b0;
      w_bad_ld = 1'b0;
      w_code   = 5'd0;
      if (exc_valid_i) begin
         if (w_int_pend) begin
            w_exc  = 1'b1;
            w_code = 5'd0;
         end else if (exc_req_i[0]) begin
            w_exc    = 1'b1;
            w_code   = 5'd4;
            w_bad_ld = 1'b1;
         end else if (exc_req_i[1]) begin
            w_exc  = 1'b1;
            w_code = 5'd10;
         end else if (exc_req_i[2]) begin
            w_exc  = 1'b1;
            w_code = 5'd12;
         end else if (exc_req_i[3]) begin
            w_exc  = 1'b1;
            w_code = 5'd8;
         end else if (exc_req_i[4]) begin
            w_exc  = 1'b1;
            w_code = 5'd9;
         end else if (exc_req_i[5]) begin
            w_exc    = 1'b1;
            w_code   = 5'd4;
            w_bad_ld = 1'b1;
         end else if (exc_req_i[6]) begin
            w_exc    = 1'b1;
            w_code   = 5'd5;
            w_bad_ld = 1'b1;
         end else if (exc_req_i[7]) begin
            w_eret = 1'b1;
         end
      end
   end

   // Redirect and status outputs are held quiet while reset is asserted.
   assign flush_o       = ~rst & (w_exc | w_eret);
   assign new_pc_o      = rst    ? 32'h0 :
                          w_exc  ? EXC_VECTOR :
                          w_eret ? r_epc : 32'h0;
   assign int_pending_o = ~rst & w_int_pend;
   assign timer_int_o   = ~rst & r_ti;
   assign status_o      = w_status;
   assign cause_o       = w_cause;
   assign epc_o         = r_epc;

   // MFC0 read mux over registered values.
   always_comb begin
      data_o = 32'h0;
      if (!rst) begin
         case (raddr_i)
            A_BADVADDR: data_o = r_badvaddr;
            A_COUNT:    data_o = r_count;
            A_COMPARE:  data_o = r_compare;
            A_STATUS:   data_o = w_status;
            A_CAUSE:    data_o = w_cause;
            A_EPC:      data_o = r_epc;
            A_PRID:     data_o = PRID;
            A_CONFIG:   data_o = CONFIG_VAL;
            default:    data_o = 32'h0;
         endcase
      end
   end

   // Count/Compare timer with prescaler; a Compare write clears TI ahead of a same-cycle match.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 32'h0;
         r_compare <= 32'h0;
         r_presc   <= '0;
         r_ti      <= 1'b0;
      end else begin
         if (w_wr_count) begin
            r_count <= data_i;
            r_presc <= '0;
         end else if (r_presc == PRE_LAST) begin
            r_count <= r_count + 32'd1;
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + PW'(1);
         end
         if (w_wr_compare) begin
            r_compare <= data_i;
            r_ti      <= 1'b0;
         end else if (r_count == r_compare) begin
            r_ti <= 1'b1;
         end
      end
   end

   // Status/Cause/EPC/BadVAddr: MTC0 first, then a taken event overrides the fields it owns.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_im       <= 8'h0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_bd       <= 1'b0;
         r_ip_hw    <= 6'h0;
         r_ip_sw    <= 2'h0;
         r_exccode  <= 5'h0;
         r_epc      <= 32'h0;
         r_badvaddr <= 32'h0;
      end else begin
         r_ip_hw <= w_int_ext;
         if (we_i) begin
            case (waddr_i)
               A_STATUS: begin
                  r_im  <= data_i[15:8];
                  r_exl <= data_i[1];
                  r_ie  <= data_i[0];
               end
               A_CAUSE:  r_ip_sw <= data_i[9:8];
               A_EPC:    r_epc   <= data_i;
               default: ;
            endcase
         end
         if (w_exc) begin
            r_exl     <= 1'b1;
            r_exccode <= w_code;
            if (!r_exl) begin
               r_epc <= in_delayslot_i ? (pc_i - 32'd4) : pc_i;
               r_bd  <= in_delayslot_i;
            end
            if (w_bad_ld) begin
               r_badvaddr <= badvaddr_i;
            end
         end else if (w_eret) begin
            r_exl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: reset, timer, interrupt, delay slot, nesting, priority, ERET, wrap.
module tb_cp0_exc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [4:0]  waddr_i, raddr_i;
   logic [31:0] data_i;
   logic [5:0]  int_i;
   logic        exc_valid_i;
   logic [7:0]  exc_req_i;
   logic [31:0] pc_i;
   logic        in_delayslot_i;
   logic [31:0] badvaddr_i;

   logic [31:0] data_o, status_o, cause_o, epc_o, new_pc_o;
   logic        flush_o, int_pending_o, timer_int_o;

   logic [31:0] data2_o, status2_o, cause2_o, epc2_o, new_pc2_o;
   logic        flush2_o, int_pending2_o, timer_int2_o;

   int errors = 0;
   int checks = 0;
   logic [31:0] v;

   always #10 clk = ~clk;

   cp0_exc_ctrl dut (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
      .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_req_i(exc_req_i),
      .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .badvaddr_i(badvaddr_i),
      .data_o(data_o), .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o), .int_pending_o(int_pending_o),
      .timer_int_o(timer_int_o)
   );

   cp0_exc_ctrl #(.COUNT_DIV(1)) dut_div1 (
      .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .raddr_i(raddr_i),
      .data_i(data_i), .int_i(int_i), .exc_valid_i(exc_valid_i), .exc_req_i(exc_req_i),
      .pc_i(pc_i), .in_delayslot_i(in_delayslot_i), .badvaddr_i(badvaddr_i),
      .data_o(data2_o), .status_o(status2_o), .cause_o(cause2_o), .epc_o(epc2_o),
      .flush_o(flush2_o), .new_pc_o(new_pc2_o), .int_pending_o(int_pending2_o),
      .timer_int_o(timer_int2_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
      tick();
      we_i = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] d);
      raddr_i = a;
      #1;
      d = data_o;
   endtask

   task automatic rd2(input logic [4:0] a, output logic [31:0] d);
      raddr_i = a;
      #1;
      d = data2_o;
   endtask

   task automatic exc(input logic [7:0] req, input logic [31:0] pc, input logic ds);
      exc_valid_i = 1'b1; exc_req_i = req; pc_i = pc; in_delayslot_i = ds;
   endtask

   task automatic no_exc();
      exc_valid_i = 1'b0; exc_req_i = 8'h0; in_delayslot_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; we_i = 1'b0; waddr_i = '0; raddr_i = 5'd15; data_i = '0; int_i = '0;
      badvaddr_i = 32'h0;
      // a pending syscall during reset must not flush or leave any trace
      exc(8'h08, 32'h500, 1'b0);
      tick(); tick(); tick();
      chk("rst_flush", {31'b0, flush_o}, 32'h0);
      chk("rst_newpc", new_pc_o, 32'h0);
      chk("rst_intpend", {31'b0, int_pending_o}, 32'h0);
      chk("rst_ti", {31'b0, timer_int_o}, 32'h0);
      chk("rst_data", data_o, 32'h0);
      no_exc();
      rst = 1'b0;
      #1;
      chk("rst_status", status_o, 32'h1040_0000);
      chk("rst_cause", cause_o, 32'h0);
      chk("rst_epc", epc_o, 32'h0);
      rd(5'd15, v); chk("prid", v, 32'h004C_0102);
      rd(5'd16, v); chk("config", v, 32'h0000_8000);
      tick();
      rd(5'd20, v); chk("unmapped", v, 32'h0);

      // timer: Compare=10, Count=0, divide by 2
      mtc0(5'd11, 32'd10);
      chk("cmp_wr_clr_ti", {31'b0, timer_int_o}, 32'h0);
      mtc0(5'd9, 32'd0);
      for (int i = 0; i < 20; i++) tick();
      rd(5'd9, v); chk("count_at_20", v, 32'd10);
      chk("ti_before", {31'b0, timer_int_o}, 32'h0);
      tick();
      chk("ti_set", {31'b0, timer_int_o}, 32'h1);
      chk("cause_ti_ip7", cause_o & 32'hC000_8000, 32'h4000_8000);
      tick(); tick(); tick();
      chk("ti_sticky", {31'b0, timer_int_o}, 32'h1);
      mtc0(5'd11, 32'd1000);
      chk("ti_clear", {31'b0, timer_int_o}, 32'h0);

      // hardware interrupt 0 with IE and IM[2]
      mtc0(5'd12, 32'h1040_0401);
      int_i = 6'b000001;
      tick();
      chk("ip2", cause_o & 32'h0000_0400, 32'h0000_0400);
      chk("int_pend", {31'b0, int_pending_o}, 32'h1);
      exc(8'h00, 32'h100, 1'b0);
      #1;
      chk("int_flush", {31'b0, flush_o}, 32'h1);
      chk("int_newpc", new_pc_o, 32'hBFC0_0380);
      tick();
      no_exc();
      int_i = 6'b0;
      #1;
      chk("int_epc", epc_o, 32'h100);
      chk("int_code", (cause_o >> 2) & 32'h1F, 32'd0);
      chk("int_exl", status_o & 32'h2, 32'h2);
      chk("int_masked", {31'b0, int_pending_o}, 32'h0);
      chk("idle_flush", {31'b0, flush_o}, 32'h0);
      chk("idle_newpc", new_pc_o, 32'h0);

      // syscall in delay slot
      mtc0(5'd12, 32'h0);
      exc(8'h08, 32'h204, 1'b1);
      tick();
      no_exc();
      chk("ds_epc", epc_o, 32'h200);
      chk("ds_bd", cause_o & 32'h8000_0000, 32'h8000_0000);
      chk("ds_code", (cause_o >> 2) & 32'h1F, 32'd8);

      // nested overflow while EXL=1
      exc(8'h04, 32'h300, 1'b0);
      #1;
      chk("nest_flush", {31'b0, flush_o}, 32'h1);
      chk("nest_newpc", new_pc_o, 32'hBFC0_0380);
      tick();
      no_exc();
      chk("nest_epc", epc_o, 32'h200);
      chk("nest_code", (cause_o >> 2) & 32'h1F, 32'd12);

      // RI beats AdES; BadVAddr must not load
      badvaddr_i = 32'h1234;
      exc(8'h42, 32'h400, 1'b0);
      tick();
      no_exc();
      chk("prio_code", (cause_o >> 2) & 32'h1F, 32'd10);
      rd(5'd8, v); chk("prio_badv", v, 32'h0);

      // ERET returns to EPC and clears EXL
      exc(8'h80, 32'h404, 1'b0);
      #1;
      chk("eret_flush", {31'b0, flush_o}, 32'h1);
      chk("eret_newpc", new_pc_o, 32'h200);
      tick();
      no_exc();
      chk("eret_exl", status_o & 32'h2, 32'h0);

      // AdES alone loads BadVAddr; exc_valid_i low means no event
      badvaddr_i = 32'hDEAD_0004;
      exc_valid_i = 1'b0; exc_req_i = 8'h40;
      #1;
      chk("novalid_flush", {31'b0, flush_o}, 32'h0);
      exc(8'h40, 32'h600, 1'b0);
      tick();
      no_exc();
      rd(5'd8, v); chk("ades_badv", v, 32'hDEAD_0004);
      chk("ades_code", (cause_o >> 2) & 32'h1F, 32'd5);
      chk("ades_epc", epc_o, 32'h600);

      // Cause write touches only IP[1:0]
      mtc0(5'd13, 32'hFFFF_FFFF);
      chk("cause_sw", cause_o & 32'h0000_FF7C, 32'h0000_0314);

      // wrap with divide-by-1 and Status write mask
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd2(5'd9, v); chk("wrap_pre", v, 32'hFFFF_FFFF);
      tick();
      rd2(5'd9, v); chk("wrap_zero", v, 32'h0);
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd(5'd12, v); chk("status_mask", v, 32'h1040_FF03);
      chk("status_div1", status2_o, 32'h1040_FF03);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter HW_INT_W, default 6, sets the hardware interrupt line count (legal 1..6).
REQ-002 Parameter COUNT_DIV, default 2, sets the clock cycles per Count increment (legal >=1).
REQ-003 Parameter EXC_VECTOR, default 32'hBFC0_0380, is the exception entry PC.
REQ-004 Parameter PRID, default 32'h004C_0102, is the PRId read value.
REQ-005 Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- we_i  in  1  MTC0 write enable.
- waddr_i  in  5  write register number.
- raddr_i  in  5  read register number.
- data_i  in  32  write data.
- int_i  in  HW_INT_W  hardware interrupt lines, level-sensitive.
- exc_valid_i  in  1  a committing instruction is present.
- exc_req_i  in  8  exception flags: [0] fetch AdEL, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] data AdEL, [6] AdES, [7] ERET.
- pc_i  in  32  committing instruction PC.
- in_delayslot_i  in  1  committing instruction is in a delay slot.
- badvaddr_i  in  32  faulting address.
- data_o  out  32  MFC0 read data.
- status_o, cause_o, epc_o  out  32 each  current register values.
- flush_o  out  1  pipeline flush.
- new_pc_o  out  32  redirect PC.
- int_pending_o  out  1  enabled interrupt pending.
- timer_int_o  out  1  Cause.TI.

Function
REQ-006 The block SHALL implement these registers: BadVAddr (8), Count (9), Compare (11), Status (12), Cause (13), EPC (14), PRId (15), Config (16).
REQ-007 Prescaler: Count increments by 1 when the prescaler reaches COUNT_DIV-1, then the prescaler returns to 0; 0xFFFF_FFFF wraps to 0.
REQ-008 A Count write loads data_i, overrides that cycle's increment, and clears the prescaler.
REQ-009 Cause.TI (bit 30) sets on the cycle Count==Compare; it stays sticky and clears only on a Compare write (the write wins over a same-cycle match).
REQ-010 Cause.IP[7:2] updates every cycle from int_i (IP[2+i]=int_i[i]); IP[7] is the OR of TI and int_i[5] when present.
REQ-011 int_pending_o = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM), derived from registered state only.
REQ-012 Writable fields:
- Status: IM[15:8], EXL[1], IE[0]; BEV[22]=1 and CU0[28]=1 are read-only.
- Cause: IP[1:0] only.
- Count, Compare, EPC: all bits.
- BadVAddr, PRId, Config: read-only.
REQ-013 An event is taken only when exc_valid_i=1, in this priority:
- interrupt (int_pending_o) code 0.
- fetch AdEL code 4.
- RI code 10.
- Ov code 12.
- Syscall code 8.
- Break code 9.
- data AdEL code 4.
- AdES code 5.
- ERET.
REQ-014 A taken exception SHALL set ExcCode and EXL<=1; if EXL was 0, it sets EPC<=in_delayslot_i ? pc_i-4 : pc_i and Cause.BD<=in_delayslot_i, otherwise EPC and BD are unchanged.
REQ-015 An AdEL or AdES exception SHALL load BadVAddr<=badvaddr_i.
REQ-016 In the same cycle as a taken exception, flush_o=1 and new_pc_o=EXC_VECTOR (combinational, zero latency).
REQ-017 A taken ERET SHALL clear EXL, assert flush_o=1, and drive new_pc_o=registered EPC.
REQ-018 When an MTC0 and a taken event occur in the same cycle, the event wins on the fields it updates; other fields take the written value.
REQ-019 data_o is a combinational mux of registered values; unmapped raddr_i reads 0.
REQ-020 With no taken event, flush_o=0 and new_pc_o=0.

Reset
REQ-021 While rst=1 at a clock edge, all of the following load their reset values:
- Status=0x1040_0000.
- Cause, EPC, BadVAddr, Count, Compare, prescaler = 0.
- Config=0x0000_8000; PRId=PRID.
REQ-022 While rst=1, flush_o, int_pending_o, timer_int_o and data_o SHALL be 0.
REQ-023 Reset mid-exception SHALL discard the event; no EPC or EXL update persists.

Verification
REQ-024 Timer: COUNT_DIV=2, write Compare=10, Count=0 -> TI/timer_int_o rise after 20 cycles; a Compare write clears it the next edge.
REQ-025 Interrupt: Status=0x1040_0401, int_i[0]=1, exc_valid_i=1, pc_i=0x100 -> flush_o=1, new_pc_o=0xBFC0_0380; next cycle EPC=0x100, ExcCode=0, EXL=1.
REQ-026 Delay slot: Syscall, pc_i=0x204, in_delayslot_i=1 -> EPC=0x200, BD=1, ExcCode=8.
REQ-027 Nested: with EXL=1, raise Ov at pc_i=0x300 -> EPC unchanged, ExcCode=12, flush_o=1.
REQ-028 Priority: RI and AdES together, badvaddr_i=0x1234 -> ExcCode=10, BadVAddr unchanged; then ERET -> EXL=0, new_pc_o=EPC.
REQ-029 Wrap: Count=0xFFFF_FFFF, COUNT_DIV=1 -> Count=0 on the next edge; a Status write of 0xFFFF_FFFF reads back 0x1040_FF03.
